// File: rtl/seq_divider_32by16_pkg.sv
// Shared constants and types for the 32-by-16 sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_32by16_pkg;

  // Dividend/quotient width and divisor/remainder width.
  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;

  // One quotient bit is produced per iteration, so this equals DIVIDEND_W.
  localparam int DIV_ITER = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [DIVIDEND_W-1:0] DIV_BY_ZERO_QUOT = 32'hFFFF_FFFF;

  // Controller states. The encoding is fixed so that debug traces stay stable.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : seq_divider_32by16_pkg

// File: rtl/adder_32.sv
// Purpose: 32-bit ripple adder with carry-in and carry-out.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i/b_i operands, carry_i carry-in, sum_o 32-bit sum, carry_o carry-out.
module Adder_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        carry_i,
  output logic [31:0] sum_o,
  output logic        carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, carry_i};

endmodule : Adder_32

// File: rtl/seq_divider_32by16_div_step.sv
// Purpose: one restoring-division step: shift in a dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
// Ports: r_i partial remainder, dividend_bit_i next dividend bit, divisor_i divisor,
//        r_o updated partial remainder, qbit_o produced quotient bit.
module div_step_17
  import seq_divider_32by16_pkg::*;
(
  input  logic [DIVISOR_W:0]   r_i,
  input  logic                 dividend_bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 qbit_o
);

  localparam int RW = DIVISOR_W + 1;

  // The remainder is always below the divisor, so its top bit is never needed
  // once shifted; the trial value is the low bits plus the incoming dividend bit.
  logic [RW-1:0] trial;
  assign trial = {r_i[DIVISOR_W-1:0], dividend_bit_i};

  // trial - divisor computed as trial + ~divisor + 1 on the shared 32-bit adder.
  // No borrow (carry-out = 1) means trial >= divisor.
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;

  assign add_a = {{(32-RW){1'b0}}, trial};
  assign add_b = ~{{(32-DIVISOR_W){1'b0}}, divisor_i};

  Adder_32 u_adder (
    .a_i     (add_a),
    .b_i     (add_b),
    .carry_i (1'b1),
    .sum_o   (add_sum),
    .carry_o (add_cout)
  );

  assign qbit_o = add_cout;
  assign r_o    = add_cout ? add_sum[RW-1:0] : trial;

  // Upper difference bits are sign extension only; r_i top bit is always 0.
  logic unused_bits;
  assign unused_bits = ^{r_i[DIVISOR_W], add_sum[31:RW]};

endmodule : div_step_17

// File: rtl/seq_divider_32by16.sv
// Purpose: 32-bit / 16-bit unsigned sequential restoring divider, Start/Busy/Done handshake.
// Latency: Done in the 33rd cycle after the accepting edge (1 cycle when divisor is 0).
// Backpressure: Start is accepted only in IDLE or DONE; Start while Busy is dropped.
// Ports: Clock_in, Reset_n_in (async, active-low), Start_in, Dividend_in32, Divisor_in16,
//        Busy_out, Done_out (1-cycle pulse), DivByZero_out, Quotient_out32, Remainder_out16.
module seq_divider_32by16 #(
  parameter int DIVIDEND_W = seq_divider_32by16_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = seq_divider_32by16_pkg::DIVISOR_W
) (
  input  logic                  Clock_in,
  input  logic                  Reset_n_in,
  input  logic                  Start_in,
  input  logic [DIVIDEND_W-1:0] Dividend_in32,
  input  logic [DIVISOR_W-1:0]  Divisor_in16,
  output logic                  Busy_out,
  output logic                  Done_out,
  output logic                  DivByZero_out,
  output logic [DIVIDEND_W-1:0] Quotient_out32,
  output logic [DIVISOR_W-1:0]  Remainder_out16
);

  import seq_divider_32by16_pkg::*;

  localparam int                CNT_W    = $clog2(DIV_ITER);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DIV_ITER - 1);

  div_state_e            state_q, state_d;
  logic [DIVISOR_W:0]    r_q, r_d;        // partial remainder
  logic [DIVIDEND_W-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]  d_q, d_d;        // latched divisor
  logic [CNT_W-1:0]      cnt_q, cnt_d;    // iteration counter
  logic [DIVIDEND_W-1:0] quot_q, quot_d;  // held result
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    step_r;
  logic                  step_qbit;

  div_step_17 u_step (
    .r_i            (r_q),
    .dividend_bit_i (q_q[DIVIDEND_W-1]),
    .divisor_i      (d_q),
    .r_o            (step_r),
    .qbit_o         (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      // DONE behaves like IDLE for acceptance so operations can run back-to-back.
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (Start_in) begin
          r_d   = '0;
          q_d   = Dividend_in32;
          d_d   = Divisor_in16;
          cnt_d = '0;
          if (Divisor_in16 == '0) begin
            // No iterations: report immediately with a saturated quotient.
            state_d = ST_DONE;
            quot_d  = DIV_BY_ZERO_QUOT;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        r_d   = step_r;
        q_d   = {q_q[DIVIDEND_W-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        // Last iteration publishes its own step result directly, so the
        // outputs change on the same edge the FSM enters DONE.
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          quot_d  = {q_q[DIVIDEND_W-2:0], step_qbit};
          rem_d   = step_r[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy_out        = (state_q == ST_RUN);
  assign Done_out        = (state_q == ST_DONE);
  assign DivByZero_out   = dbz_q;
  assign Quotient_out32  = quot_q;
  assign Remainder_out16 = rem_q;

endmodule : seq_divider_32by16

// File: tb/tb_seq_divider_32by16.sv
module tb_seq_divider_32by16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, dbz;
  logic [31:0] quot;
  logic [15:0] rem;

  always #5 clk = ~clk;

  seq_divider_32by16 dut (
    .Clock_in        (clk),
    .Reset_n_in      (rst_n),
    .Start_in        (start),
    .Dividend_in32   (dividend),
    .Divisor_in16    (divisor),
    .Busy_out        (busy),
    .Done_out        (done),
    .DivByZero_out   (dbz),
    .Quotient_out32  (quot),
    .Remainder_out16 (rem)
  );

  typedef struct packed {
    logic [31:0] q;
    logic [15:0] r;
    logic        z;
  } exp_t;

  exp_t        sb[$];
  exp_t        pending = '0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_q = '0;
  logic [15:0] last_r = '0;
  logic        last_z = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse pops the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got Done=1 with no outstanding operation");
        end else begin
          e = sb.pop_front();
          check("sb_quotient", quot, e.q);
          check("sb_remainder", {16'd0, rem}, {16'd0, e.r});
          check("sb_divbyzero", {31'd0, dbz}, {31'd0, e.z});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [31:0] dd, input logic [15:0] dv, input logic [31:0] eq,
                       input logic [15:0] er, input logic ez, input bit expect_done);
    if (expect_done) begin
      pending = '{eq, er, ez};
      sb.push_back(pending);
    end
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // Operands must not be resampled after the accepting edge.
    dividend = 32'hA5A5_5A5A;
    divisor  = 16'h1234;
  endtask

  // lat counts cycles after the accepting edge (1 = first cycle after it).
  task automatic wait_done(input int exp_lat, input int start_lat, input string name);
    int lat = start_lat;
    int busy_n = 0;
    bit held_ok = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      if (quot !== last_q || rem !== last_r || dbz !== last_z) held_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, "_done_seen"}, {31'd0, done}, 32'd1);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, busy_n, exp_lat - start_lat);
    if (exp_lat > start_lat) check({name, "_outputs_held"}, {31'd0, held_ok}, 32'd1);
    last_q = pending.q;
    last_r = pending.r;
    last_z = pending.z;
  endtask

  task automatic check_idle_after_done(input string name);
    @(negedge clk);
    check({name, "_done_pulse_width"}, {31'd0, done}, 32'd0);
    check({name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_dbz"}, {31'd0, dbz}, 32'd0);
    check({name, "_quot"}, quot, 32'd0);
    check({name, "_rem"}, {16'd0, rem}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, prod;

    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    issue(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b1);
    wait_done(33, 1, "d100_7");
    check_idle_after_done("d100_7");

    issue(32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0, 1'b1);
    wait_done(33, 1, "dmax_max");
    check_idle_after_done("dmax_max");

    issue(32'd3, 16'd10, 32'd0, 16'd3, 1'b0, 1'b1);
    wait_done(33, 1, "d3_10");
    check_idle_after_done("d3_10");

    issue(32'd12345, 16'd0, 32'hFFFF_FFFF, 16'h0000, 1'b1, 1'b1);
    wait_done(1, 1, "div0");
    check_idle_after_done("div0");

    // Start while busy must be ignored: result stays 100/7.
    issue(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(33, 11, "busy_start");
    check_idle_after_done("busy_start");

    // Reset in the middle of an operation: no Done, outputs cleared.
    issue(32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("midrun_still_busy", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("post_reset");
    last_q = '0;
    last_r = '0;
    last_z = 1'b0;
    issue(32'd50, 16'd5, 32'd10, 16'd0, 1'b0, 1'b1);
    wait_done(33, 1, "d50_5");
    check_idle_after_done("d50_5");

    // Back-to-back: second Start issued in the DONE cycle.
    issue(32'd9, 16'd2, 32'd4, 16'd1, 1'b0, 1'b1);
    wait_done(33, 1, "d9_2");
    issue(32'd1000, 16'd3, 32'd333, 16'd1, 1'b0, 1'b1);
    wait_done(33, 1, "d1000_3");
    check_idle_after_done("d1000_3");

    for (int i = 0; i < 8; i++) begin
      a    = 32'($urandom_range(0, 65535));
      b    = 32'($urandom_range(1, 65535));
      prod = a * b;
      issue(prod, b[15:0], a, 16'd0, 1'b0, 1'b1);
      wait_done(33, 1, "rand_product");
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_seq_divider_32by16
